// File: rtl/uart_tx_ctrl_if.sv
// Register-block side of the UART transmitter: write strobe, frame configuration,
// oversample pulse, serial line and FIFO status.
interface uart_tx_ctrl_if #(
    parameter int DW = 8
);
    logic          tx_sample_pulse;
    logic          data_bits;
    logic          parity_en;
    logic          parity_odd0_even1;
    logic          stop_bits;
    logic          tx_data_reg_wr;
    logic [DW-1:0] tx_data;
    logic          UART_TX;
    logic          tx_busy;
    logic          tx_full;
    logic          tx_empty;
    logic          overflow;

    modport master (
        output tx_sample_pulse, data_bits, parity_en, parity_odd0_even1, stop_bits,
        output tx_data_reg_wr, tx_data,
        input  UART_TX, tx_busy, tx_full, tx_empty, overflow
    );

    modport slave (
        input  tx_sample_pulse, data_bits, parity_en, parity_odd0_even1, stop_bits,
        input  tx_data_reg_wr, tx_data,
        output UART_TX, tx_busy, tx_full, tx_empty, overflow
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit control: TX FIFO plus start/data/parity/stop serialiser, LSB first,
// timed by the shared 16x oversample pulse.
module uart_tx_ctrl #(
    parameter int UART_DATA_WIDTH        = 8,
    parameter int UART_TX_FIFO_DEPTH     = 8,
    parameter int UART_TX_FIFO_PTR_WIDTH = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    uart_tx_ctrl_if.slave         bus
);
    localparam int DW = UART_DATA_WIDTH;
    localparam int PW = UART_TX_FIFO_PTR_WIDTH;
    localparam int AW = PW - 1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    function automatic logic calc_parity(input logic [DW-1:0] d, input logic use_all,
                                         input logic even);
        logic p;
        p = use_all ? (^d) : (^d[DW-2:0]);
        return even ? p : ~p;
    endfunction

    state_e          state_q, state_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [3:0]      sample_cnt_q, sample_cnt_d;
    logic            stop_cnt_q, stop_cnt_d;
    logic            data8_q, data8_d;
    logic            par_en_q, par_en_d;
    logic            stop2_q, stop2_d;
    logic            par_bit_q, par_bit_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ovf_q, ovf_d;
    logic            tx_q, tx_d;
    logic            busy_q, busy_d;

    logic [DW-1:0]   fifo_mem_q [UART_TX_FIFO_DEPTH];
    logic [DW-1:0]   head_s;
    logic            wr_accept_s;
    logic            pop_s;
    logic            bit_end_s;
    logic [2:0]      last_bit_s;

    assign head_s     = fifo_mem_q[rd_ptr_q[AW-1:0]];
    assign last_bit_s = data8_q ? 3'd7 : 3'd6;

    // Next-state for FIFO pointers, frame sequencing and the decoded line value.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        data8_d      = data8_q;
        par_en_d     = par_en_q;
        stop2_d      = stop2_q;
        par_bit_d    = par_bit_q;
        pop_s        = 1'b0;
        wr_accept_s  = bus.tx_data_reg_wr && !full_q;
        bit_end_s    = bus.tx_sample_pulse && (sample_cnt_q == 4'd15);

        if ((state_q != ST_IDLE) && bus.tx_sample_pulse) begin
            sample_cnt_d = sample_cnt_q + 4'd1;
        end else begin
            sample_cnt_d = sample_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (!empty_q) begin
                    // Configuration is captured here so mid-frame changes only affect the next frame.
                    pop_s        = 1'b1;
                    shift_d      = head_s;
                    data8_d      = bus.data_bits;
                    par_en_d     = bus.parity_en;
                    stop2_d      = bus.stop_bits;
                    par_bit_d    = calc_parity(head_s, bus.data_bits, bus.parity_odd0_even1);
                    sample_cnt_d = 4'd0;
                    bit_cnt_d    = 3'd0;
                    stop_cnt_d   = 1'b0;
                    state_d      = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_d   = {1'b0, shift_q[DW-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == last_bit_s) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s && stop2_q && !stop_cnt_q) begin
                    stop_cnt_d = 1'b1;
                end else if (bit_end_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_accept_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) && (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
        empty_d = (wr_ptr_d == rd_ptr_d);
        ovf_d   = bus.tx_data_reg_wr && full_q;

        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_bit_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counters, pointers and registered outputs.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= 3'd0;
            sample_cnt_q <= 4'd0;
            stop_cnt_q   <= 1'b0;
            data8_q      <= 1'b0;
            par_en_q     <= 1'b0;
            stop2_q      <= 1'b0;
            par_bit_q    <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
            ovf_q        <= 1'b0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            stop_cnt_q   <= stop_cnt_d;
            data8_q      <= data8_d;
            par_en_q     <= par_en_d;
            stop2_q      <= stop2_d;
            par_bit_q    <= par_bit_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            full_q       <= full_d;
            empty_q      <= empty_d;
            ovf_q        <= ovf_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge ACLK) begin
        if (wr_accept_s) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.tx_data;
        end
    end

    assign bus.UART_TX  = tx_q;
    assign bus.tx_busy  = busy_q;
    assign bus.tx_full  = full_q;
    assign bus.tx_empty = empty_q;
    assign bus.overflow = ovf_q;
endmodule
